// File: rtl/riscv_pkg.sv
// Shared decode constants and small types for the riscv_exec_core slice.
package riscv_pkg;

   // Major opcodes of the supported subset
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;

   // funct3 encodings for register/immediate ALU ops
   localparam logic [2:0] F3_ADD_SUB = 3'b000;
   localparam logic [2:0] F3_SLT     = 3'b010;
   localparam logic [2:0] F3_XOR     = 3'b100;
   localparam logic [2:0] F3_OR      = 3'b110;
   localparam logic [2:0] F3_AND     = 3'b111;

   // funct3 encodings for conditional branches
   localparam logic [2:0] F3_BEQ = 3'b000;
   localparam logic [2:0] F3_BNE = 3'b001;
   localparam logic [2:0] F3_BLT = 3'b100;
   localparam logic [2:0] F3_BGE = 3'b101;

   // funct7 encodings for OP
   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_SUB  = 7'b0100000;

   typedef enum logic [2:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_AND,
      ALU_OR,
      ALU_XOR,
      ALU_SLT,
      ALU_PASS_B
   } alu_op_e;

   typedef enum logic {
      ST_RUN,
      ST_HALT
   } core_state_e;

endpackage

// File: rtl/riscv_regfile.sv
// Architectural register file: two combinational read ports, one
// synchronous write port, x0 hardwired to zero, asynchronous clear.
module riscv_regfile #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32,
   parameter int AW    = $clog2(NREGS)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [AW-1:0]   raddr_a_i,
   output logic [XLEN-1:0] rdata_a_o,
   input  logic [AW-1:0]   raddr_b_i,
   output logic [XLEN-1:0] rdata_b_o,
   input  logic            we_i,
   input  logic [AW-1:0]   waddr_i,
   input  logic [XLEN-1:0] wdata_i
);

   logic [XLEN-1:0] regs_q [NREGS];

   // Register storage: cleared on reset, writes to x0 dropped
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= '0;
         end
      end else if (we_i && (waddr_i != '0)) begin
         regs_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_a_o = (raddr_a_i == '0) ? '0 : regs_q[raddr_a_i];
   assign rdata_b_o = (raddr_b_i == '0) ? '0 : regs_q[raddr_b_i];

endmodule

// File: rtl/riscv_exec_core.sv
// Single-cycle execute core: decode, ALU, branch resolution and PC update
// happen combinationally; all architectural state changes on the accepting
// edge. An illegal instruction parks the core in HALT until halt_clr.
module riscv_exec_core
   import riscv_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter int              NREGS    = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            instr_valid,
   input  logic [31:0]     instr,
   output logic            instr_ready,
   input  logic            halt_clr,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] aluresult,
   output logic            branch_taken,
   output logic            retire,
   output logic            illegal_instr,
   output logic            halted
);

   localparam int AW = $clog2(NREGS);

   // Register index fields are 5 bits; anything past NREGS is illegal
   function automatic logic reg_bad(input logic [4:0] idx);
      return (32'(idx) >= 32'(NREGS));
   endfunction

   core_state_e     state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] alu_q, alu_d;
   logic            bt_q, bt_d;
   logic            retire_q, retire_d;
   logic            illegal_q, illegal_d;

   // Instruction fields
   logic [6:0] opcode, funct7;
   logic [2:0] funct3;
   logic [4:0] rd_idx, rs1_idx, rs2_idx;

   assign opcode  = instr[6:0];
   assign rd_idx  = instr[11:7];
   assign funct3  = instr[14:12];
   assign rs1_idx = instr[19:15];
   assign rs2_idx = instr[24:20];
   assign funct7  = instr[31:25];

   // Immediates are built at 32 bits then truncated to XLEN, which yields
   // sign extension for XLEN=32 and the low-bits rule for XLEN=16.
   logic [31:0]     imm_i32, imm_b32, imm_j32, imm_u32;
   logic [XLEN-1:0] imm_i, imm_b, imm_j, imm_u;

   assign imm_i32 = {{20{instr[31]}}, instr[31:20]};
   assign imm_b32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
   assign imm_j32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
   assign imm_u32 = {instr[31:12], 12'b0};
   assign imm_i   = imm_i32[XLEN-1:0];
   assign imm_b   = imm_b32[XLEN-1:0];
   assign imm_j   = imm_j32[XLEN-1:0];
   assign imm_u   = imm_u32[XLEN-1:0];

   // Register file
   logic [XLEN-1:0] rs1_data, rs2_data, wdata;
   logic            we;

   riscv_regfile #(
      .XLEN  (XLEN),
      .NREGS (NREGS),
      .AW    (AW)
   ) u_regfile (
      .clk       (clk),
      .rst_n     (rst_n),
      .raddr_a_i (rs1_idx[AW-1:0]),
      .rdata_a_o (rs1_data),
      .raddr_b_i (rs2_idx[AW-1:0]),
      .rdata_b_o (rs2_data),
      .we_i      (we),
      .waddr_i   (rd_idx[AW-1:0]),
      .wdata_i   (wdata)
   );

   // Decode
   logic            known, uses_rs1, uses_rs2, uses_rd, is_branch, is_jal, instr_ok;
   alu_op_e         alu_op;
   logic [XLEN-1:0] op_b;

   // Classify the instruction, pick ALU op and second operand
   always_comb begin
      known     = 1'b0;
      uses_rs1  = 1'b0;
      uses_rs2  = 1'b0;
      uses_rd   = 1'b0;
      is_branch = 1'b0;
      is_jal    = 1'b0;
      alu_op    = ALU_ADD;
      op_b      = rs2_data;
      unique case (opcode)
         OPC_OP: begin
            uses_rs1 = 1'b1;
            uses_rs2 = 1'b1;
            uses_rd  = 1'b1;
            if (funct7 == F7_BASE) begin
               known = 1'b1;
               unique case (funct3)
                  F3_ADD_SUB: alu_op = ALU_ADD;
                  F3_SLT:     alu_op = ALU_SLT;
                  F3_XOR:     alu_op = ALU_XOR;
                  F3_OR:      alu_op = ALU_OR;
                  F3_AND:     alu_op = ALU_AND;
                  default:    known  = 1'b0;
               endcase
            end else if (funct7 == F7_SUB && funct3 == F3_ADD_SUB) begin
               known  = 1'b1;
               alu_op = ALU_SUB;
            end
         end
         OPC_OP_IMM: begin
            uses_rs1 = 1'b1;
            uses_rd  = 1'b1;
            op_b     = imm_i;
            known    = (funct3 == F3_ADD_SUB);
         end
         OPC_LUI: begin
            uses_rd = 1'b1;
            alu_op  = ALU_PASS_B;
            op_b    = imm_u;
            known   = 1'b1;
         end
         OPC_BRANCH: begin
            uses_rs1  = 1'b1;
            uses_rs2  = 1'b1;
            is_branch = 1'b1;
            alu_op    = ALU_SUB;
            known     = (funct3 == F3_BEQ) || (funct3 == F3_BNE) ||
                        (funct3 == F3_BLT) || (funct3 == F3_BGE);
         end
         OPC_JAL: begin
            uses_rd = 1'b1;
            is_jal  = 1'b1;
            known   = 1'b1;
         end
         default: ;
      endcase
      instr_ok = known && !(uses_rs1 && reg_bad(rs1_idx)) &&
                 !(uses_rs2 && reg_bad(rs2_idx)) && !(uses_rd && reg_bad(rd_idx));
   end

   // ALU
   logic [XLEN-1:0] alu_res;
   logic            lt_signed;

   assign lt_signed = $signed(rs1_data) < $signed(op_b);

   // Inline ALU; operand b is either rs2 or the selected immediate
   always_comb begin
      alu_res = '0;
      unique case (alu_op)
         ALU_ADD:    alu_res = rs1_data + op_b;
         ALU_SUB:    alu_res = rs1_data - op_b;
         ALU_AND:    alu_res = rs1_data & op_b;
         ALU_OR:     alu_res = rs1_data | op_b;
         ALU_XOR:    alu_res = rs1_data ^ op_b;
         ALU_SLT:    alu_res = {{(XLEN-1){1'b0}}, lt_signed};
         ALU_PASS_B: alu_res = op_b;
         default:    alu_res = '0;
      endcase
   end

   // Branch condition; for branches op_b is rs2 so lt_signed applies
   logic br_cond;

   always_comb begin
      br_cond = 1'b0;
      unique case (funct3)
         F3_BEQ:  br_cond = (rs1_data == rs2_data);
         F3_BNE:  br_cond = (rs1_data != rs2_data);
         F3_BLT:  br_cond = lt_signed;
         F3_BGE:  br_cond = !lt_signed;
         default: br_cond = 1'b0;
      endcase
   end

   logic            accept;
   logic [XLEN-1:0] pc_plus4;

   assign accept   = instr_valid && (state_q == ST_RUN);
   assign pc_plus4 = pc_q + XLEN'(4);

   // FSM next state: illegal accept halts, halt_clr resumes
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_RUN:  if (accept && !instr_ok) state_d = ST_HALT;
         ST_HALT: if (halt_clr) state_d = ST_RUN;
         default: state_d = ST_RUN;
      endcase
   end

   // Datapath next state: PC, result, flags and register write
   always_comb begin
      pc_d      = pc_q;
      alu_d     = alu_q;
      bt_d      = bt_q;
      retire_d  = 1'b0;
      illegal_d = 1'b0;
      we        = 1'b0;
      wdata     = alu_res;
      if (accept) begin
         if (instr_ok) begin
            retire_d = 1'b1;
            we       = uses_rd;
            if (is_jal) begin
               pc_d  = pc_q + imm_j;
               bt_d  = 1'b1;
               alu_d = pc_plus4;
               wdata = pc_plus4;
            end else if (is_branch && br_cond) begin
               pc_d  = pc_q + imm_b;
               bt_d  = 1'b1;
               alu_d = alu_res;
            end else begin
               pc_d  = pc_plus4;
               bt_d  = 1'b0;
               alu_d = alu_res;
            end
         end else begin
            illegal_d = 1'b1;
         end
      end
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_RUN;
         pc_q      <= RESET_PC;
         alu_q     <= '0;
         bt_q      <= 1'b0;
         retire_q  <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         alu_q     <= alu_d;
         bt_q      <= bt_d;
         retire_q  <= retire_d;
         illegal_q <= illegal_d;
      end
   end

   assign instr_ready   = (state_q == ST_RUN);
   assign halted        = (state_q == ST_HALT);
   assign pc            = pc_q;
   assign aluresult     = alu_q;
   assign branch_taken  = bt_q;
   assign retire        = retire_q;
   assign illegal_instr = illegal_q;

endmodule

// File: tb/tb_riscv_exec_core.sv
// Directed bench: a 32/32 core (A) and a 16-bit, 16-register core (B).
module tb_riscv_exec_core;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Core A: XLEN=32, NREGS=32
   logic        rst_a_n, a_valid, a_hclr, a_ready, a_bt, a_ret, a_ill, a_halt;
   logic [31:0] a_instr, a_pc, a_alu;

   riscv_exec_core #(.XLEN(32), .NREGS(32), .RESET_PC(32'h0)) dut_a (
      .clk(clk), .rst_n(rst_a_n), .instr_valid(a_valid), .instr(a_instr),
      .instr_ready(a_ready), .halt_clr(a_hclr), .pc(a_pc), .aluresult(a_alu),
      .branch_taken(a_bt), .retire(a_ret), .illegal_instr(a_ill), .halted(a_halt)
   );

   // Core B: XLEN=16, NREGS=16
   logic        rst_b_n, b_valid, b_hclr, b_ready, b_bt, b_ret, b_ill, b_halt;
   logic [31:0] b_instr;
   logic [15:0] b_pc, b_alu;

   riscv_exec_core #(.XLEN(16), .NREGS(16), .RESET_PC(16'h0)) dut_b (
      .clk(clk), .rst_n(rst_b_n), .instr_valid(b_valid), .instr(b_instr),
      .instr_ready(b_ready), .halt_clr(b_hclr), .pc(b_pc), .aluresult(b_alu),
      .branch_taken(b_bt), .retire(b_ret), .illegal_instr(b_ill), .halted(b_halt)
   );

   typedef struct {
      logic [31:0] instr;
      logic [31:0] alu;
      logic [31:0] pc;
      logic        bt;
      logic        chk_alu;
   } vec_t;

   vec_t tab_a [19];
   vec_t tab_b [5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic step_a(input logic [31:0] ins);
      a_valid = 1'b1;
      a_instr = ins;
      @(posedge clk);
      #1;
      a_valid = 1'b0;
   endtask

   task automatic step_b(input logic [31:0] ins);
      b_valid = 1'b1;
      b_instr = ins;
      @(posedge clk);
      #1;
      b_valid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      // instr, alu, pc, branch_taken, check alu
      tab_a[0]  = '{32'h00500093, 32'd5,        32'h04, 1'b0, 1'b1}; // addi x1,x0,5
      tab_a[1]  = '{32'h00A00113, 32'd10,       32'h08, 1'b0, 1'b1}; // addi x2,x0,10
      tab_a[2]  = '{32'h002081B3, 32'd15,       32'h0C, 1'b0, 1'b1}; // add x3,x1,x2
      tab_a[3]  = '{32'h00208463, 32'd0,        32'h10, 1'b0, 1'b0}; // beq not taken
      tab_a[4]  = '{32'h00209463, 32'hFFFFFFFB, 32'h18, 1'b1, 1'b1}; // bne taken +8
      tab_a[5]  = '{32'h402081B3, 32'hFFFFFFFB, 32'h1C, 1'b0, 1'b1}; // sub x3=5-10
      tab_a[6]  = '{32'h010000EF, 32'h20,       32'h2C, 1'b1, 1'b1}; // jal x1,+16
      tab_a[7]  = '{32'h00008233, 32'h20,       32'h30, 1'b0, 1'b1}; // add x4,x1,x0
      tab_a[8]  = '{32'h0021F2B3, 32'h0A,       32'h34, 1'b0, 1'b1}; // and x5,x3,x2
      tab_a[9]  = '{32'h0020E2B3, 32'h2A,       32'h38, 1'b0, 1'b1}; // or  x5,x1,x2
      tab_a[10] = '{32'h0021C2B3, 32'hFFFFFFF1, 32'h3C, 1'b0, 1'b1}; // xor x5,x3,x2
      tab_a[11] = '{32'h0021A2B3, 32'd1,        32'h40, 1'b0, 1'b1}; // slt -5<10
      tab_a[12] = '{32'h003122B3, 32'd0,        32'h44, 1'b0, 1'b1}; // slt 10<-5
      tab_a[13] = '{32'h12345337, 32'h12345000, 32'h48, 1'b0, 1'b1}; // lui x6
      tab_a[14] = '{32'h00708013, 32'h27,       32'h4C, 1'b0, 1'b1}; // addi x0,x1,7
      tab_a[15] = '{32'h000003B3, 32'd0,        32'h50, 1'b0, 1'b1}; // add x7,x0,x0
      tab_a[16] = '{32'hFE21CCE3, 32'hFFFFFFF1, 32'h48, 1'b1, 1'b1}; // blt x3,x2,-8
      tab_a[17] = '{32'hFE21DCE3, 32'd0,        32'h4C, 1'b0, 1'b0}; // bge x3,x2 no
      tab_a[18] = '{32'h00315663, 32'd15,       32'h58, 1'b1, 1'b1}; // bge x2,x3,+12

      tab_b[0]  = '{32'hFFF00093, 32'hFFFF,     32'h04, 1'b0, 1'b1}; // addi x1,x0,-1
      tab_b[1]  = '{32'h00108093, 32'h0000,     32'h08, 1'b0, 1'b1}; // addi wraps
      tab_b[2]  = '{32'h00308093, 32'h0003,     32'h0C, 1'b0, 1'b1}; // addi x1,x1,3
      tab_b[3]  = '{32'h00400113, 32'h0004,     32'h10, 1'b0, 1'b1}; // addi x2,x0,4
      tab_b[4]  = '{32'hFFFFF237, 32'hF000,     32'h14, 1'b0, 1'b1}; // lui low bits

      rst_a_n = 1'b0; a_valid = 1'b0; a_hclr = 1'b0; a_instr = '0;
      rst_b_n = 1'b0; b_valid = 1'b0; b_hclr = 1'b0; b_instr = '0;

      #12;
      chk("a_reset_pc", a_pc, 32'h0);
      chk("a_reset_alu", a_alu, 32'h0);
      chk("a_reset_flags", {a_bt, a_ret, a_ill, a_halt, a_ready}, 32'b00001);
      chk("b_reset_pc", 32'(b_pc), 32'h0);
      chk("b_reset_flags", {b_bt, b_ret, b_ill, b_halt, b_ready}, 32'b00001);
      @(negedge clk);
      rst_a_n = 1'b1;
      rst_b_n = 1'b1;

      // Core A table
      for (int i = 0; i < 19; i++) begin
         step_a(tab_a[i].instr);
         $display("A vec %0d instr=%h pc=%h alu=%h bt=%b ret=%b", i, tab_a[i].instr, a_pc, a_alu, a_bt, a_ret);
         chk($sformatf("a%0d_retire", i), {a_ret, a_ill}, 32'b10);
         chk($sformatf("a%0d_pc", i), a_pc, tab_a[i].pc);
         chk($sformatf("a%0d_bt", i), 32'(a_bt), 32'(tab_a[i].bt));
         if (tab_a[i].chk_alu) chk($sformatf("a%0d_alu", i), a_alu, tab_a[i].alu);
      end

      // No accept: everything holds, retire drops
      @(posedge clk); #1;
      $display("A idle pc=%h alu=%h", a_pc, a_alu);
      chk("a_idle_retire", 32'(a_ret), 32'd0);
      chk("a_idle_hold", {a_pc, a_alu}, {32'h58, 32'd15});
      chk("a_idle_bt", 32'(a_bt), 32'd1);

      // halt_clr in RUN is ignored
      a_hclr = 1'b1;
      @(posedge clk); #1;
      a_hclr = 1'b0;
      $display("A halt_clr in RUN halted=%b ready=%b", a_halt, a_ready);
      chk("a_clr_in_run", {a_halt, a_ready}, 32'b01);

      // Illegal funct7 halts
      step_a(32'h022081B3);
      $display("A illegal f7 ill=%b halted=%b pc=%h", a_ill, a_halt, a_pc);
      chk("a_ill_flags", {a_ill, a_ret, a_halt, a_ready}, 32'b1010);
      chk("a_ill_pc", a_pc, 32'h58);

      // Valid instruction while halted is not taken
      step_a(32'h00008233);
      $display("A halted valid ill=%b ret=%b pc=%h", a_ill, a_ret, a_pc);
      chk("a_halt_noaccept", {a_ill, a_ret, a_halt}, 32'b001);
      chk("a_halt_pc", a_pc, 32'h58);

      // halt_clr with instr_valid: resume but do not accept
      a_hclr = 1'b1;
      step_a(32'h00008233);
      a_hclr = 1'b0;
      $display("A halt_clr+valid halted=%b ret=%b pc=%h", a_halt, a_ret, a_pc);
      chk("a_resume_flags", {a_halt, a_ready, a_ret}, 32'b010);
      chk("a_resume_pc", a_pc, 32'h58);

      step_a(32'h00008233);
      $display("A resumed add pc=%h alu=%h", a_pc, a_alu);
      chk("a_resume_alu", a_alu, 32'h20);
      chk("a_resume_pc2", a_pc, 32'h5C);

      // Asynchronous reset between edges
      #3;
      rst_a_n = 1'b0;
      #1;
      $display("A async reset pc=%h alu=%h", a_pc, a_alu);
      chk("a_areset_pc", a_pc, 32'h0);
      chk("a_areset_alu", a_alu, 32'h0);
      chk("a_areset_flags", {a_bt, a_ret, a_ill, a_halt}, 32'b0000);
      @(negedge clk);
      rst_a_n = 1'b1;
      step_a(32'h00008233);
      $display("A post-reset add x4,x1,x0 pc=%h alu=%h", a_pc, a_alu);
      chk("a_x1_cleared", a_alu, 32'h0);
      chk("a_post_reset_pc", a_pc, 32'h4);

      // Core B table
      for (int i = 0; i < 5; i++) begin
         step_b(tab_b[i].instr);
         $display("B vec %0d instr=%h pc=%h alu=%h", i, tab_b[i].instr, b_pc, b_alu);
         chk($sformatf("b%0d_retire", i), {b_ret, b_ill}, 32'b10);
         chk($sformatf("b%0d_pc", i), 32'(b_pc), tab_b[i].pc);
         chk($sformatf("b%0d_alu", i), 32'(b_alu), tab_b[i].alu);
      end

      // rd=x17 is illegal with 16 registers
      step_b(32'h002088B3);
      $display("B illegal rd ill=%b halted=%b ready=%b pc=%h", b_ill, b_halt, b_ready, b_pc);
      chk("b_ill_flags", {b_ill, b_ret, b_halt, b_ready}, 32'b1010);
      chk("b_ill_pc", 32'(b_pc), 32'h14);

      b_hclr = 1'b1;
      @(posedge clk); #1;
      b_hclr = 1'b0;
      $display("B halt_clr halted=%b ready=%b", b_halt, b_ready);
      chk("b_clr_flags", {b_halt, b_ready, b_ill}, 32'b010);

      // x1 must still hold 3 (no write from the illegal instruction)
      step_b(32'h000081B3);
      $display("B add x3,x1,x0 pc=%h alu=%h", b_pc, b_alu);
      chk("b_no_write", 32'(b_alu), 32'h3);
      chk("b_after_pc", 32'(b_pc), 32'h18);

      // rs1=x16 on ADDI is illegal as well
      step_b(32'h00080093);
      $display("B illegal rs1 ill=%b halted=%b pc=%h", b_ill, b_halt, b_pc);
      chk("b_ill_rs1", {b_ill, b_halt}, 32'b11);
      chk("b_ill_rs1_pc", 32'(b_pc), 32'h18);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/riscv_exec_core.md
Name: riscv_exec_core

Overview:
Parametrised successor to riscv_simple. It is a single-issue, single-cycle execute core with its own program counter, a parametrised register file, a valid/ready instruction handshake and a halt-on-illegal state machine.
Instructions are supplied externally, one per accepted cycle; the core does not fetch. Results, branch decisions and PC are registered and observable one clock after acceptance.
Supported set: ADD, SUB, AND, OR, XOR, SLT, ADDI, LUI, BEQ, BNE, BLT, BGE, JAL.

Parameters:
XLEN, 32, datapath and register width (legal values 16 or 32).
NREGS, 32, number of architectural registers (16 = RV32E-style, 32 = full).
RESET_PC, 0, PC value after reset; XLEN bits wide.

Ports:
clk  in  1  core clock; all state updates on the rising edge.
rst_n  in  1  asynchronous, active-low reset.
instr_valid  in  1  instr holds an instruction to execute.
instr  in  32  RV32 instruction word.
instr_ready  out  1  core accepts instr this cycle; equals (state==RUN).
halt_clr  in  1  leave HALT state.
pc  out  XLEN  address of the next instruction to be accepted.
aluresult  out  XLEN  result of the last retired instruction.
branch_taken  out  1  the last retired instruction redirected the PC.
retire  out  1  one-cycle pulse: an instruction retired on the previous edge.
illegal_instr  out  1  one-cycle pulse: the last accepted instruction was illegal.
halted  out  1  core is in the HALT state.

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC; aluresult=0, branch_taken=0, retire=0, illegal_instr=0, halted=0.
  - All registers are 0; state=RUN.
  - Reset asserted mid-cycle discards any in-flight write.
- Accept condition: instr_valid && instr_ready at a rising edge. Decode and execute are combinational; all architectural updates happen on that edge. Latency is one clock to the outputs.
- No accept: registers, pc, aluresult and branch_taken hold their values; retire=0.
- Register x0: always reads 0. Writes to x0 are discarded, but aluresult still shows the computed value.
- Width and arithmetic rules:
  - Immediates are sign-extended to XLEN.
  - ADD/SUB/ADDI wrap modulo 2^XLEN.
  - SLT is signed and returns 0 or 1.
  - LUI with XLEN=16 uses the low 16 bits of imm<<12.
- Branches:
  - Taken: pc += sext(B-imm), branch_taken=1, aluresult = rs1-rs2.
  - Not taken: pc += 4, branch_taken=0.
  - BLT/BGE compare signed.
- JAL: rd = pc+4; pc += sext(J-imm); branch_taken=1; aluresult = pc+4.
- All other legal instructions: pc += 4 (wraps at XLEN bits), branch_taken=0.
- Illegal instruction: any of
  - an unsupported opcode, funct3 or funct7;
  - any rs1/rs2/rd index >= NREGS for the fields that instruction uses.
  Response: no register write, pc unchanged, retire=0, illegal_instr=1 for one cycle, state -> HALT.
- State machine RUN/HALT:
  - RUN -> HALT: an illegal instruction is accepted.
  - HALT -> RUN: halt_clr=1 at an edge.
  - In HALT, instr_ready=0 and halted=1. halt_clr together with instr_valid in HALT does not accept the instruction; acceptance resumes the following cycle.
  - halt_clr while in RUN is ignored.
- Read-after-write: a write on edge N is visible to the instruction accepted at edge N+1. No forwarding hazard exists because execution is single-cycle.

Decomposition:
- Shared package riscv_pkg, with defines.v retained for legacy includes. It holds:
  - opcode constants (OP, OP_IMM, LUI, BRANCH, JAL);
  - funct3/funct7 constants;
  - the ALU-op enum (ADD, SUB, AND, OR, XOR, SLT, PASS_B);
  - the RUN/HALT state typedef.
- Sub-module riscv_regfile: parametrised by XLEN and NREGS; two async read ports, one sync write port, x0 hardwired, async reset clear.
- The ALU stays inline in riscv_exec_core.

Test Plan:
1. XLEN=32, NREGS=32, RESET_PC=0. Issue 0x00500093, 0x00A00113, 0x002081B3.
   -> aluresult=15 after the third edge; pc=0x0C; retire pulses each cycle.
2. Issue BEQ 0x00208463 with x1=5, x2=10 -> branch_taken=0, pc+=4.
   Then issue BNE 0x00209463 -> branch_taken=1, pc+=8.
3. Issue SUB 0x402081B3 (5-10) -> aluresult=0xFFFFFFFB.
   Then issue JAL 0x010000EF at pc=P -> x1=P+4, pc=P+16, branch_taken=1.
4. XLEN=16. Issue 0xFFF00093 -> aluresult=0xFFFF. Then issue 0x00108093 -> aluresult=0x0000 (wrap).
5. NREGS=16. Issue 0x002088B3 (rd=x17):
   -> illegal_instr pulses, halted=1, instr_ready=0, pc unchanged, no write occurs.
   Then assert halt_clr for one cycle -> halted=0, instr_ready=1 next cycle.
6. Assert rst_n=0 asynchronously mid-stream, between edges.
   -> outputs zero immediately, pc=RESET_PC, x1 reads 0 afterwards, halted=0.
